// File: rtl/cpu_pkg.sv
// Shared pipeline constants, fetch state encoding and opcode helpers.
package cpu_pkg;

   localparam int unsigned PC_W    = 8;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned OP_MSB  = INSTR_W - 1;
   localparam int unsigned OP_LSB  = INSTR_W - OP_W;

   localparam logic [OP_W-1:0]    HALT_OP   = 4'hF;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[OP_MSB:OP_LSB];
   endfunction

   function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
      return opcode_of(instr) == HALT_OP;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register with hold (stall), clear to bubble (flush) and load.
// Flush overrides stall so a redirect is never lost behind a stalled consumer.
module ifid_reg #(
   parameter int unsigned        PcW      = 8,
   parameter int unsigned        InstrW   = 16,
   parameter logic [InstrW-1:0]  NopInstr = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              load,
   input  logic [InstrW-1:0] d_instr,
   input  logic [PcW-1:0]    d_pc,
   input  logic              d_valid,
   output logic [InstrW-1:0] instr,
   output logic [PcW-1:0]    pc,
   output logic              valid
);

   logic [InstrW-1:0] instr_q;
   logic [PcW-1:0]    pc_q;
   logic              valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= NopInstr;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         instr_q <= NopInstr;
         valid_q <= 1'b0;
      end else if (load && !stall) begin
         instr_q <= d_instr;
         pc_q    <= d_pc;
         valid_q <= d_valid;
      end
   end

   assign instr = instr_q;
   assign pc    = pc_q;
   assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and loads the IF/ID register, with stall, redirect and HALT handling.
module if_stage
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [PC_W-1:0]    redirect_pc_i,
   output logic               imem_en,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [PC_W-1:0]    pc_o,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic               ifid_valid,
   output logic               halted_o
);

   fetch_state_e    state_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] inflight_pc_q;
   logic            inflight_v_q;
   logic            halted_q;

   logic advance;
   logic ifid_flush;
   logic ifid_load;

   // An advance consumes the word fetched last cycle and issues the next one.
   assign advance    = (state_q == RUN) && !stall_i && !redirect_i;
   assign ifid_load  = advance;
   assign ifid_flush = redirect_i || ((state_q == HALT) && !stall_i);

   always_comb begin
      imem_en = 1'b0;
      case (state_q)
         RUN:     imem_en = !stall_i || redirect_i;
         default: imem_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= BOOT;
         pc_q          <= '0;
         inflight_pc_q <= '0;
         inflight_v_q  <= 1'b0;
         halted_q      <= 1'b0;
      end else if (redirect_i) begin
         // Also squashes a HALT that was fetched down the wrong path.
         state_q      <= RUN;
         pc_q         <= redirect_pc_i;
         inflight_v_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         case (state_q)
            BOOT: state_q <= RUN;
            RUN: begin
               if (!stall_i) begin
                  pc_q          <= pc_q + 1'b1;
                  inflight_pc_q <= pc_q;
                  inflight_v_q  <= 1'b1;
                  if (inflight_v_q && is_halt(imem_rdata)) begin
                     state_q  <= HALT;
                     halted_q <= 1'b1;
                  end
               end
            end
            HALT:    state_q <= HALT;
            default: state_q <= BOOT;
         endcase
      end
   end

   ifid_reg #(
      .PcW      (PC_W),
      .InstrW   (INSTR_W),
      .NopInstr (NOP_INSTR)
   ) u_ifid_reg (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall_i),
      .flush   (ifid_flush),
      .load    (ifid_load),
      .d_instr (imem_rdata),
      .d_pc    (inflight_pc_q),
      .d_valid (inflight_v_q),
      .instr   (ifid_instr),
      .pc      (ifid_pc),
      .valid   (ifid_valid)
   );

   assign imem_addr = pc_q;
   assign pc_o      = pc_q;
   assign halted_o  = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural 1-cycle-latency instruction memory.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [7:0]  redirect_pc_i = 8'h00;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata = 16'h0000;
   logic [7:0]  pc_o;
   logic [15:0] ifid_instr;
   logic [7:0]  ifid_pc;
   logic        ifid_valid;
   logic        halted_o;

   logic [15:0] mem [256];
   int checks = 0;
   int errors = 0;

   if_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_en       (imem_en),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .pc_o          (pc_o),
      .ifid_instr    (ifid_instr),
      .ifid_pc       (ifid_pc),
      .ifid_valid    (ifid_valid),
      .halted_o      (halted_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 8'h00;
      step();
      rst = 1'b0;
   endtask

   task automatic fill_mem();
      for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pc_o !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc_o); end
      checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", imem_addr); end
      checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", imem_en); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
      checks++; if (ifid_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp 0000", ifid_instr); end
      checks++; if (ifid_pc !== 8'h00) begin errors++; $display("FAIL reset_ifid_pc got %h exp 00", ifid_pc); end
      checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted_o); end
   endtask

   task automatic test_sequential();
      do_reset();
      step();  // leave BOOT
      checks++; if (pc_o !== 8'h00) begin errors++; $display("FAIL seq_run_pc got %h exp 00", pc_o); end
      checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL seq_run_en got %b exp 1", imem_en); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL seq_valid0 got %b exp 0", ifid_valid); end
      step();
      checks++; if (pc_o !== 8'h01) begin errors++; $display("FAIL seq_pc1 got %h exp 01", pc_o); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL seq_valid1 got %b exp 0", ifid_valid); end
      for (int k = 0; k < 5; k++) begin
         step();
         checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL seq_valid k=%0d got %b exp 1", k, ifid_valid); end
         checks++; if (ifid_pc !== 8'(k)) begin errors++; $display("FAIL seq_ifid_pc got %h exp %h", ifid_pc, 8'(k)); end
         checks++; if (ifid_instr !== 16'h1000 + 16'(k)) begin errors++; $display("FAIL seq_instr got %h exp %h", ifid_instr, 16'h1000 + 16'(k)); end
         checks++; if (pc_o !== 8'(k + 2)) begin errors++; $display("FAIL seq_pc got %h exp %h", pc_o, 8'(k + 2)); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      steps(6);  // ifid_pc = 3, pc = 5
      checks++; if (ifid_pc !== 8'h03) begin errors++; $display("FAIL stall_pre_ifid_pc got %h exp 03", ifid_pc); end
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL stall_en got %b exp 0", imem_en); end
         step();
         checks++; if (pc_o !== 8'h05) begin errors++; $display("FAIL stall_pc got %h exp 05", pc_o); end
         checks++; if (ifid_pc !== 8'h03) begin errors++; $display("FAIL stall_ifid_pc got %h exp 03", ifid_pc); end
         checks++; if (ifid_instr !== 16'h1003) begin errors++; $display("FAIL stall_instr got %h exp 1003", ifid_instr); end
         checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", ifid_valid); end
      end
      stall_i = 1'b0;
      #1;
      checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL stall_release_en got %b exp 1", imem_en); end
      step();
      checks++; if (ifid_pc !== 8'h04) begin errors++; $display("FAIL stall_next_pc got %h exp 04", ifid_pc); end
      checks++; if (ifid_instr !== 16'h1004) begin errors++; $display("FAIL stall_next_instr got %h exp 1004", ifid_instr); end
      checks++; if (pc_o !== 8'h06) begin errors++; $display("FAIL stall_next_fetch got %h exp 06", pc_o); end
      step();
      checks++; if (ifid_instr !== 16'h1005) begin errors++; $display("FAIL stall_after_instr got %h exp 1005", ifid_instr); end
   endtask

   task automatic test_redirect(input logic with_stall);
      do_reset();
      steps(8);  // ifid_pc = 5
      checks++; if (ifid_pc !== 8'h05) begin errors++; $display("FAIL redir_pre_ifid_pc got %h exp 05", ifid_pc); end
      redirect_i = 1'b1; redirect_pc_i = 8'h40; stall_i = with_stall;
      #1;
      checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL redir_en stall=%b got %b exp 1", with_stall, imem_en); end
      step();
      redirect_i = 1'b0; stall_i = 1'b0;
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble1 stall=%b got %b exp 0", with_stall, ifid_valid); end
      checks++; if (ifid_instr !== 16'h0000) begin errors++; $display("FAIL redir_nop stall=%b got %h exp 0000", with_stall, ifid_instr); end
      checks++; if (pc_o !== 8'h40) begin errors++; $display("FAIL redir_pc stall=%b got %h exp 40", with_stall, pc_o); end
      step();
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble2 stall=%b got %b exp 0", with_stall, ifid_valid); end
      checks++; if (pc_o !== 8'h41) begin errors++; $display("FAIL redir_pc2 stall=%b got %h exp 41", with_stall, pc_o); end
      step();
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL redir_valid stall=%b got %b exp 1", with_stall, ifid_valid); end
      checks++; if (ifid_pc !== 8'h40) begin errors++; $display("FAIL redir_ifid_pc stall=%b got %h exp 40", with_stall, ifid_pc); end
      checks++; if (ifid_instr !== 16'h1040) begin errors++; $display("FAIL redir_instr stall=%b got %h exp 1040", with_stall, ifid_instr); end
   endtask

   task automatic test_halt();
      mem[6] = 16'hF000;
      do_reset();
      steps(9);  // entry 6 loaded
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_valid got %b exp 1", ifid_valid); end
      checks++; if (ifid_pc !== 8'h06) begin errors++; $display("FAIL halt_ifid_pc got %h exp 06", ifid_pc); end
      checks++; if (ifid_instr !== 16'hF000) begin errors++; $display("FAIL halt_instr got %h exp F000", ifid_instr); end
      checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL halt_halted got %b exp 1", halted_o); end
      checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL halt_en got %b exp 0", imem_en); end
      checks++; if (pc_o !== 8'h08) begin errors++; $display("FAIL halt_pc got %h exp 08", pc_o); end
      stall_i = 1'b1;
      step();
      checks++; if (ifid_instr !== 16'hF000) begin errors++; $display("FAIL halt_stall_instr got %h exp F000", ifid_instr); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_stall_valid got %b exp 1", ifid_valid); end
      stall_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_bubble got %b exp 0", ifid_valid); end
         checks++; if (pc_o !== 8'h08) begin errors++; $display("FAIL halt_pc_frozen got %h exp 08", pc_o); end
         checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL halt_stays got %b exp 1", halted_o); end
         checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL halt_en_stays got %b exp 0", imem_en); end
      end
      mem[6] = 16'h1006;
   endtask

   task automatic test_squash();
      mem[6] = 16'hF000;
      // Redirect after the HALT has been loaded.
      do_reset();
      steps(9);
      checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL squash_pre got %b exp 1", halted_o); end
      redirect_i = 1'b1; redirect_pc_i = 8'h20;
      step();
      redirect_i = 1'b0;
      checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL squash_halted got %b exp 0", halted_o); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL squash_bubble got %b exp 0", ifid_valid); end
      checks++; if (pc_o !== 8'h20) begin errors++; $display("FAIL squash_pc got %h exp 20", pc_o); end
      steps(2);
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL squash_valid got %b exp 1", ifid_valid); end
      checks++; if (ifid_pc !== 8'h20) begin errors++; $display("FAIL squash_ifid_pc got %h exp 20", ifid_pc); end
      checks++; if (ifid_instr !== 16'h1020) begin errors++; $display("FAIL squash_instr got %h exp 1020", ifid_instr); end
      // Redirect on the very edge the HALT would have been loaded.
      do_reset();
      steps(8);
      redirect_i = 1'b1; redirect_pc_i = 8'h30;
      step();
      redirect_i = 1'b0;
      checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL squash_same_halted got %b exp 0", halted_o); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL squash_same_valid got %b exp 0", ifid_valid); end
      steps(2);
      checks++; if (ifid_instr !== 16'h1030) begin errors++; $display("FAIL squash_same_instr got %h exp 1030", ifid_instr); end
      checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL squash_same_run got %b exp 0", halted_o); end
      mem[6] = 16'h1006;
   endtask

   task automatic test_wrap();
      do_reset();
      step();
      redirect_i = 1'b1; redirect_pc_i = 8'hFE;
      step();
      redirect_i = 1'b0;
      step();
      checks++; if (pc_o !== 8'hFF) begin errors++; $display("FAIL wrap_pc_ff got %h exp FF", pc_o); end
      step();
      checks++; if (pc_o !== 8'h00) begin errors++; $display("FAIL wrap_pc_00 got %h exp 00", pc_o); end
      checks++; if (ifid_pc !== 8'hFE) begin errors++; $display("FAIL wrap_ifid_fe got %h exp FE", ifid_pc); end
      checks++; if (ifid_instr !== 16'h10FE) begin errors++; $display("FAIL wrap_instr_fe got %h exp 10FE", ifid_instr); end
      step();
      checks++; if (ifid_pc !== 8'hFF) begin errors++; $display("FAIL wrap_ifid_ff got %h exp FF", ifid_pc); end
      checks++; if (ifid_instr !== 16'h10FF) begin errors++; $display("FAIL wrap_instr_ff got %h exp 10FF", ifid_instr); end
      step();
      checks++; if (ifid_pc !== 8'h00) begin errors++; $display("FAIL wrap_ifid_00 got %h exp 00", ifid_pc); end
      checks++; if (ifid_instr !== 16'h1000) begin errors++; $display("FAIL wrap_instr_00 got %h exp 1000", ifid_instr); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", ifid_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      steps(7);  // ifid_pc = 4, pc = 6
      rst = 1'b1;
      step();
      checks++; if (pc_o !== 8'h00) begin errors++; $display("FAIL mid_pc got %h exp 00", pc_o); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", ifid_valid); end
      checks++; if (ifid_pc !== 8'h00) begin errors++; $display("FAIL mid_ifid_pc got %h exp 00", ifid_pc); end
      checks++; if (ifid_instr !== 16'h0000) begin errors++; $display("FAIL mid_instr got %h exp 0000", ifid_instr); end
      checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL mid_en got %b exp 0", imem_en); end
      checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL mid_halted got %b exp 0", halted_o); end
      rst = 1'b0;
      steps(2);
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL mid_refetch_bubble got %b exp 0", ifid_valid); end
      step();
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL mid_refetch_valid got %b exp 1", ifid_valid); end
      checks++; if (ifid_pc !== 8'h00) begin errors++; $display("FAIL mid_refetch_pc got %h exp 00", ifid_pc); end
      checks++; if (ifid_instr !== 16'h1000) begin errors++; $display("FAIL mid_refetch_instr got %h exp 1000", ifid_instr); end
   endtask

   initial begin
      fill_mem();
      test_reset();
      test_sequential();
      test_stall();
      test_redirect(1'b0);
      test_redirect(1'b1);
      test_halt();
      test_squash();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
